// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; the result is held in resp_result until the consumer takes it.
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [2:0]      div_op,
  input  logic            req_valid,
  output logic            req_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_valid,
  input  logic            resp_ready
);
  localparam int W  = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0] quot, rem, dvs;
  logic [CW-1:0]   cnt;
  logic            word_r, rem_sel, neg_q, neg_r;

  function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] x, input logic w);
    return w ? {{(XLEN-W){x[W-1]}}, x[W-1:0]} : x;
  endfunction

  // Operand preparation, evaluated against the live request inputs.
  logic            is_signed, sgn1, sgn2, div_zero, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_q, spec_r;

  always_comb begin
    is_signed = ~div_op[0];
    a_ext = operand1;
    b_ext = operand2;
    if (div_op[2]) begin
      a_ext = {{(XLEN-W){is_signed & operand1[W-1]}}, operand1[W-1:0]};
      b_ext = {{(XLEN-W){is_signed & operand2[W-1]}}, operand2[W-1:0]};
    end
    sgn1  = is_signed & a_ext[XLEN-1];
    sgn2  = is_signed & b_ext[XLEN-1];
    a_mag = sgn1 ? -a_ext : a_ext;
    b_mag = sgn2 ? -b_ext : b_ext;
    min_val = div_op[2] ? {{(XLEN-W+1){1'b1}}, {(W-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = is_signed && (b_ext == '1) && (a_ext == min_val);
    special  = div_zero | ovf;
    spec_q = div_zero ? '1 : a_ext;
    spec_r = div_zero ? a_ext : '0;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [XLEN:0]   rem_sh, diff;
  logic            take, last;
  logic [XLEN-1:0] rem_nxt, quot_nxt, q_fin, r_fin, res_iter;

  always_comb begin
    rem_sh   = {rem, quot[XLEN-1]};
    diff     = rem_sh - {1'b0, dvs};
    take     = ~diff[XLEN];
    rem_nxt  = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quot_nxt = {quot[XLEN-2:0], take};
    last     = (cnt == (word_r ? CW'(W-1) : CW'(XLEN-1)));
    q_fin    = neg_q ? -quot_nxt : quot_nxt;
    r_fin    = neg_r ? -rem_nxt : rem_nxt;
    res_iter = fin(rem_sel ? r_fin : q_fin, word_r);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = special ? DONE : BUSY;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_result <= '0;
      quot        <= '0;
      rem         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      word_r      <= 1'b0;
      rem_sel     <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          // Word dividends are pre-shifted so the quotient MSB always sits at the top.
          quot    <= div_op[2] ? (a_mag << W) : a_mag;
          rem     <= '0;
          dvs     <= b_mag;
          cnt     <= '0;
          word_r  <= div_op[2];
          rem_sel <= div_op[1];
          neg_q   <= sgn1 ^ sgn2;
          neg_r   <= sgn1;
          if (special) resp_result <= fin(div_op[1] ? spec_r : spec_q, div_op[2]);
        end
        BUSY: begin
          quot <= quot_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt + 1'b1;
          if (last) resp_result <= res_iter;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed RV64M cases plus randomized ops against an arithmetic model.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] operand1, operand2;
  logic [2:0]  div_op;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [63:0] resp_result;

  div_iter #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2), .div_op(div_op),
    .req_valid(req_valid), .req_ready(req_ready), .resp_result(resp_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  bit          checking = 0;
  bit          pending = 0;
  logic [63:0] exp_res;
  time         exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic abort_run(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout at %0t", name, $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Reference: RISC-V division semantics expressed with plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, s32;
    logic [63:0] q, r;
    if (op[2]) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin q32 = '1; r32 = a32; end
      else if (op[0]) begin q32 = a32 / b32; r32 = a32 % b32; end
      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
      else begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      s32 = op[1] ? r32 : q32;
      return {{32{s32[31]}}, s32};
    end
    if (b == 0) begin q = '1; r = a; end
    else if (op[0]) begin q = a / b; r = a % b; end
    else if (a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; end
    else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    return op[1] ? r : q;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2]) begin
      if (b[31:0] == 0) return 1;
      if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 0) return 1;
    if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  // Cycle-by-cycle check of every output against the model state.
  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("req_ready", {63'd0, req_ready}, {63'd0, !pending});
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, pending && ($time >= exp_t)});
      if (pending && resp_valid) chk("resp_result", resp_result, exp_res);
    end
  end

  task automatic start_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int w;
    div_op = op; operand1 = a; operand2 = b; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) abort_run("req_ready_wait");
    @(posedge clk);
    pending = 1'b1;
    exp_res = model(op, a, b);
    exp_t   = $time + (model_lat(op, a, b) - 1) * 10 + 5;
    #1;
    req_valid = 1'b0;
    operand1 = {$urandom, $urandom};
    operand2 = {$urandom, $urandom};
    div_op   = 3'($urandom);
    resp_ready = 1'($urandom);
  endtask

  task automatic run(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                     input int bp, input bit noise, input bit has_lit, input logic [63:0] lit);
    int w;
    start_req(op, a, b);
    w = 0;
    do begin @(negedge clk); w++; end while (!resp_valid && w < 200);
    if (!resp_valid) abort_run("resp_valid_wait");
    resp_ready = 1'b0;
    if (has_lit) chk("literal", resp_result, lit);
    for (int i = 0; i < bp; i++) begin
      if (noise) begin
        req_valid = 1'b1; div_op = 3'b001; operand1 = {$urandom, $urandom}; operand2 = 64'd3;
      end
      @(negedge clk);
    end
    if (noise) chk("bp_hold", resp_result, lit);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    pending = 1'b0;
    #1 resp_ready = 1'b0;
  endtask

  function automatic logic [63:0] pick(input bit divisor);
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 200));
      2: return divisor ? 64'd0 : {$urandom, $urandom};
      3: return 64'h8000_0000_0000_0000;
      4: return divisor ? {$urandom, 32'hFFFF_FFFF} : {$urandom, 32'h8000_0000};
      default: return '1;
    endcase
  endfunction

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    operand1 = '0; operand2 = '0; div_op = '0;

    // Pin the model with hand-computed values.
    chk("pin_div", model(3'b000, 64'd100, 64'd7), 64'd14);
    chk("pin_rem", model(3'b010, 64'd100, 64'd7), 64'd2);
    chk("pin_divneg", model(3'b000, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_remuw0", model(3'b111, 64'h1_8000_0000, 64'h1_0000_0000), 64'hFFFF_FFFF_8000_0000);
    chk("pin_lat", 64'(model_lat(3'b100, 64'd9, 64'd3)), 64'd33);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", resp_result, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    checking = 1'b1;

    run(3'b000, 64'd100, 64'd7, 0, 0, 1, 64'd14);
    run(3'b010, 64'd100, 64'd7, 1, 0, 1, 64'd2);
    run(3'b000, -64'sd7, 64'd2, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    run(3'b010, -64'sd7, 64'd2, 2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF);
    run(3'b001, 64'd5, 64'd0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run(3'b011, 64'd5, 64'd0, 0, 0, 1, 64'd5);
    run(3'b000, 64'h8000_0000_0000_0000, '1, 0, 0, 1, 64'h8000_0000_0000_0000);
    run(3'b010, 64'h8000_0000_0000_0000, '1, 0, 0, 1, 64'd0);
    run(3'b101, 64'h1_8000_0000, 64'd1, 0, 0, 1, 64'hFFFF_FFFF_8000_0000);
    run(3'b100, 64'h0000_0000_8000_0000, '1, 0, 0, 1, 64'hFFFF_FFFF_8000_0000);
    run(3'b000, 64'd1000, 64'd10, 10, 1, 1, 64'd100);
    run(3'b011, 64'd17, 64'd5, 0, 0, 1, 64'd2);

    // Reset in the middle of a divide.
    start_req(3'b001, {$urandom, $urandom}, 64'd12345);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    pending = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    run(3'b000, 64'd9, 64'd3, 0, 0, 1, 64'd3);

    for (int i = 0; i < 60; i++)
      run(3'($urandom), pick(0), pick(1), $urandom_range(0, 3), 0, 0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
